// File: rtl/timer_pkg.sv
// Shared constants for the countdown timer: register offsets, FSM states,
// mode codes and CTRL field positions.
package timer_pkg;

   // Word offsets decoded from Addr[3:2]
   localparam logic [1:0] TIMER_CTRL   = 2'd0;
   localparam logic [1:0] TIMER_PRESET = 2'd1;
   localparam logic [1:0] TIMER_COUNT  = 2'd2;
   localparam logic [1:0] TIMER_RSVD   = 2'd3;

   // Countdown sequencer states
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   // Mode codes; 2 and 3 fall back to one-shot behaviour
   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   // Assemble the CTRL read word from its fields; unused bits read as zero
   function automatic logic [31:0] pack_ctrl(input logic en,
                                             input logic [1:0] mode,
                                             input logic im);
      return {28'd0, im, mode, en};
   endfunction

endpackage

// File: rtl/timer_if.sv
// Bridge-side bus of the timer: address, write strobe/data, read data and IRQ.
interface timer_if;

   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   // Bridge side drives the access, timer answers with read data and IRQ
   modport master (output Addr, output WE, output Din, input Dout, input IRQ);
   modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);

endinterface

// File: rtl/timer.sv
// Memory-mapped countdown timer with one-shot (sticky IRQ) and auto-reload
// (single-cycle IRQ pulse) modes. IRQ feeds CP0 HW[0] through the bridge.
module timer
   import timer_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   timer_if.slave bus
);

   logic        ctrl_en;
   logic [1:0]  ctrl_mode;
   logic        ctrl_im;
   logic [31:0] preset;
   logic [31:0] count;
   logic        pending;
   state_t      state;

   logic [1:0]  reg_sel;
   logic        ctrl_wr;
   logic        preset_wr;
   logic        pending_set;
   logic        unused_bits;

   assign reg_sel   = bus.Addr[3:2];
   assign ctrl_wr   = bus.WE && (reg_sel == TIMER_CTRL);
   assign preset_wr = bus.WE && (reg_sel == TIMER_PRESET);

   // Expiry in this cycle; a concurrent CTRL write must not swallow it
   assign pending_set = (state == S_CNT) && ctrl_en && (count <= 32'd1);

   // Address bits outside [3:2] and undefined CTRL bits are deliberately ignored
   assign unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:4]};

   // Sequencer plus CTRL/pending; software CTRL writes override FSM field updates
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         count     <= 32'd0;
         pending   <= 1'b0;
         ctrl_en   <= 1'b0;
         ctrl_mode <= MODE_ONESHOT;
         ctrl_im   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ctrl_en) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               count <= preset;
               state <= S_CNT;
            end
            S_CNT: begin
               if (!ctrl_en) begin
                  state <= S_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  count   <= 32'd0;
                  pending <= 1'b1;
                  state   <= S_INT;
               end
            end
            S_INT: begin
               if (ctrl_mode == MODE_RELOAD) begin
                  pending <= 1'b0;
                  state   <= S_LOAD;
               end else begin
                  ctrl_en <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (ctrl_wr) begin
            ctrl_en   <= bus.Din[CTRL_EN];
            ctrl_mode <= bus.Din[CTRL_MODE_HI:CTRL_MODE_LO];
            ctrl_im   <= bus.Din[CTRL_IM];
            if (!pending_set) begin
               pending <= 1'b0;
            end
         end
      end
   end

   // PRESET only changes on a software write; LOAD samples the pre-edge value
   always_ff @(posedge clk) begin
      if (reset) begin
         preset <= 32'd0;
      end else if (preset_wr) begin
         preset <= bus.Din;
      end
   end

   // Combinational read mux
   always_comb begin
      bus.Dout = 32'd0;
      case (reg_sel)
         TIMER_CTRL:   bus.Dout = pack_ctrl(ctrl_en, ctrl_mode, ctrl_im);
         TIMER_PRESET: bus.Dout = preset;
         TIMER_COUNT:  bus.Dout = count;
         default:      bus.Dout = 32'd0;
      endcase
   end

   assign bus.IRQ = pending & ctrl_im;

endmodule

// File: tb/tb_timer.sv
// Directed bench for the countdown timer: a vector table for the basic
// one-shot flow plus hand-written sequences for multi-cycle corner cases.
module tb_timer;

   localparam logic [31:0] A_CTRL   = 32'h0;
   localparam logic [31:0] A_PRESET = 32'h4;
   localparam logic [31:0] A_COUNT  = 32'h8;
   localparam logic [31:0] A_RSVD   = 32'hC;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        we;
      logic [31:0] din;
      logic [31:0] exp_dout;
      logic        exp_irq;
   } vec_t;

   logic   clk;
   logic   reset;
   int     checks;
   int     errors;
   vec_t   vecs[16];

   timer_if bus();

   timer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence never completes
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one access at the falling edge, then settle 1 time unit past the rising edge
   task automatic applyStimulus(input logic [31:0] addr, input logic we,
                                input logic [31:0] din, input logic rst);
      @(negedge clk);
      bus.Addr = addr;
      bus.WE   = we;
      bus.Din  = din;
      reset    = rst;
      @(posedge clk);
      #1;
   endtask

   // Compare read data and IRQ against hand-computed values
   task automatic checkOutput(input string name, input logic [31:0] exp_dout,
                              input logic exp_irq);
      checks++;
      if (bus.Dout !== exp_dout) begin
         errors++;
         $display("[TB] FAIL %s dout: got 0x%08h expected 0x%08h", name, bus.Dout, exp_dout);
      end
      checks++;
      if (bus.IRQ !== exp_irq) begin
         errors++;
         $display("[TB] FAIL %s irq: got %0b expected %0b", name, bus.IRQ, exp_irq);
      end
   endtask

   task automatic setVec(input int i, input string n, input logic [31:0] a,
                         input logic w, input logic [31:0] d,
                         input logic [31:0] ed, input logic ei);
      vecs[i].name     = n;
      vecs[i].addr     = a;
      vecs[i].we       = w;
      vecs[i].din      = d;
      vecs[i].exp_dout = ed;
      vecs[i].exp_irq  = ei;
   endtask

   initial begin
      logic [31:0] exp_cnt;
      logic        exp_irq;
      int          p;

      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      bus.Addr = 32'h0;
      bus.WE   = 1'b0;
      bus.Din  = 32'h0;

      // Reset reads, then one-shot PRESET=5 with CTRL=0x9 written at edge t (vector 5)
      setVec(0,  "rst_ctrl",     A_CTRL,   1'b0, 32'h0, 32'h0, 1'b0);
      setVec(1,  "rst_preset",   A_PRESET, 1'b0, 32'h0, 32'h0, 1'b0);
      setVec(2,  "rst_count",    A_COUNT,  1'b0, 32'h0, 32'h0, 1'b0);
      setVec(3,  "rst_rsvd",     A_RSVD,   1'b0, 32'h0, 32'h0, 1'b0);
      setVec(4,  "wr_preset5",   A_PRESET, 1'b1, 32'h5, 32'h5, 1'b0);
      setVec(5,  "wr_ctrl9",     A_CTRL,   1'b1, 32'h9, 32'h9, 1'b0);
      setVec(6,  "os_t1_load",   A_COUNT,  1'b0, 32'h0, 32'h0, 1'b0);
      setVec(7,  "os_t2_cnt5",   A_COUNT,  1'b0, 32'h0, 32'h5, 1'b0);
      setVec(8,  "os_t3_cnt4",   A_COUNT,  1'b0, 32'h0, 32'h4, 1'b0);
      setVec(9,  "os_t4_cnt3",   A_COUNT,  1'b0, 32'h0, 32'h3, 1'b0);
      setVec(10, "os_t5_cnt2",   A_COUNT,  1'b0, 32'h0, 32'h2, 1'b0);
      setVec(11, "os_t6_cnt1",   A_COUNT,  1'b0, 32'h0, 32'h1, 1'b0);
      setVec(12, "os_t7_expire", A_COUNT,  1'b0, 32'h0, 32'h0, 1'b1);
      setVec(13, "os_t8_en_clr", A_CTRL,   1'b0, 32'h0, 32'h8, 1'b1);
      setVec(14, "os_t9_sticky", A_CTRL,   1'b0, 32'h0, 32'h8, 1'b1);
      setVec(15, "os_ack_ctrl8", A_CTRL,   1'b1, 32'h8, 32'h8, 1'b0);

      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b1);
      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].din, 1'b0);
         checkOutput(vecs[i].name, vecs[i].exp_dout, vecs[i].exp_irq);
      end

      // Auto-reload PRESET=3: pending at t+5, then one pulse every 5 cycles
      $display("[TB] auto-reload sequence");
      applyStimulus(A_PRESET, 1'b1, 32'h3, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'hB, 1'b0);
      for (int k = 1; k <= 22; k++) begin
         applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
         if (k < 2) begin
            exp_cnt = 32'd0;
            exp_irq = 1'b0;
         end else begin
            p = (k - 2) % 5;
            case (p)
               0: exp_cnt = 32'd3;
               1: exp_cnt = 32'd2;
               2: exp_cnt = 32'd1;
               default: exp_cnt = 32'd0;
            endcase
            exp_irq = (p == 3);
         end
         checkOutput($sformatf("reload_k%0d", k), exp_cnt, exp_irq);
      end
      applyStimulus(A_CTRL, 1'b1, 32'h0, 1'b0);
      checkOutput("reload_stop", 32'h0, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("reload_stopped_cnt", 32'h2, 1'b0);

      // Mid-count disable: disable lands on the edge where COUNT becomes 6
      $display("[TB] mid-count disable sequence");
      applyStimulus(A_PRESET, 1'b1, 32'd10, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
         exp_cnt = (k == 1) ? 32'd2 : 32'(12 - k);
         checkOutput($sformatf("dis_k%0d", k), exp_cnt, 1'b0);
      end
      applyStimulus(A_CTRL, 1'b1, 32'h8, 1'b0);
      checkOutput("dis_write", 32'h8, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
         checkOutput($sformatf("dis_hold%0d", k), 32'd6, 1'b0);
      end
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("reen_load", 32'd6, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("reen_cnt10", 32'd10, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h0, 1'b0);
      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b0);

      // Simultaneous events: pending set beats a CTRL write; CTRL write beats INT's EN clear
      $display("[TB] simultaneous-event sequence");
      applyStimulus(A_PRESET, 1'b1, 32'h1, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("sim_k1", 32'd9, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("sim_k2", 32'd1, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      checkOutput("sim_set_wins", 32'h9, 1'b1);
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      checkOutput("sim_sw_wins", 32'h9, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b0);
      end
      checkOutput("sim_idle", 32'h0, 1'b0);

      // Masked expiry, then enabling IM must not surface the stale pending
      $display("[TB] masked sequence");
      applyStimulus(A_PRESET, 1'b1, 32'h2, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h1, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
         case (k)
            1: exp_cnt = 32'd1;
            2: exp_cnt = 32'd2;
            3: exp_cnt = 32'd1;
            default: exp_cnt = 32'd0;
         endcase
         checkOutput($sformatf("mask_k%0d", k), exp_cnt, 1'b0);
      end
      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b0);
      checkOutput("mask_en_cleared", 32'h0, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h8, 1'b0);
      checkOutput("mask_im_on", 32'h8, 1'b0);
      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b0);
      checkOutput("mask_no_spur", 32'h8, 1'b0);

      // PRESET=0 expires on the same cycle as PRESET=1 (t+3)
      $display("[TB] preset-zero sequence");
      applyStimulus(A_PRESET, 1'b1, 32'h0, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("p0_k1", 32'd0, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("p0_k2", 32'd0, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      checkOutput("p0_k3_expire", 32'd0, 1'b1);
      applyStimulus(A_CTRL, 1'b1, 32'h8, 1'b0);
      checkOutput("p0_ack", 32'h8, 1'b0);

      // Reset in the middle of a count clears everything at once
      $display("[TB] reset-mid-count sequence");
      applyStimulus(A_PRESET, 1'b1, 32'h8, 1'b0);
      applyStimulus(A_CTRL, 1'b1, 32'h9, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      end
      checkOutput("rst_mid_cnt4", 32'd4, 1'b0);
      applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b1);
      checkOutput("rst_mid_count", 32'd0, 1'b0);
      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b0);
      checkOutput("rst_mid_ctrl", 32'd0, 1'b0);
      applyStimulus(A_PRESET, 1'b0, 32'h0, 1'b0);
      checkOutput("rst_mid_preset", 32'd0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(A_COUNT, 1'b0, 32'h0, 1'b0);
      end
      checkOutput("rst_mid_quiet", 32'd0, 1'b0);

      // Writes to COUNT and the reserved slot have no effect
      $display("[TB] ignored-write sequence");
      applyStimulus(A_COUNT, 1'b1, 32'h1234, 1'b0);
      checkOutput("wr_count_ign", 32'h0, 1'b0);
      applyStimulus(A_RSVD, 1'b1, 32'h5555, 1'b0);
      checkOutput("wr_rsvd_ign", 32'h0, 1'b0);
      applyStimulus(A_PRESET, 1'b0, 32'h0, 1'b0);
      checkOutput("rsvd_preset", 32'h0, 1'b0);
      applyStimulus(A_CTRL, 1'b0, 32'h0, 1'b0);
      checkOutput("rsvd_ctrl", 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer.md
Name: timer

Overview:
- Memory-mapped countdown timer device on the system bridge.
- Its IRQ output drives bit 0 of the CP0 hardware-interrupt input HW[5:0], through the bridge.
- Software programs it with SW to three word registers: CTRL, PRESET and COUNT.
- Supports a one-shot mode (sticky interrupt) and an auto-reload mode (one-cycle interrupt pulse).

Parameters:
- none (register map and widths are fixed; constants live in the shared package)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Addr  in  32  byte address from bridge; only Addr[3:2] decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
- WE  in  1  write enable, already qualified by bridge address select
- Din  in  32  write data
- Dout  out  32  read data, combinational from Addr[3:2]
- IRQ  out  1  interrupt request to CP0 HW[0]

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE. Consequently IRQ=0 and Dout reflects the zeroed registers. Reset mid-count aborts immediately with no IRQ.
- CTRL fields:
  - [0] EN
  - [2:1] MODE: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0
  - [3] IM
  - Other bits write-ignored and read 0.
- Reads:
  - CTRL returns {28'd0, IM, MODE, EN}.
  - PRESET returns the full 32 bits.
  - COUNT returns the current count.
  - reserved returns 0.
- Writes (WE=1, on posedge):
  - CTRL: updates fields and clears pending.
  - PRESET: updates PRESET only; COUNT is unaffected until the next LOAD.
  - COUNT, reserved: ignored.
- IRQ = pending & IM (combinational).
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: EN=1 -> LOAD; else stay. COUNT holds.
  - LOAD: COUNT<=PRESET; ->CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT holds.
    - else COUNT>1 -> COUNT<=COUNT-1.
    - else (COUNT is 0 or 1) -> COUNT<=0, pending<=1, ->INT.
  - INT, MODE 0: EN<=0, ->IDLE. pending stays 1 until a CTRL write or reset.
  - INT, MODE 1: pending<=0, ->LOAD. EN stays 1.
- Latency: CTRL write with EN=1 sampled at posedge t.
  - LOAD at t+1; COUNT=PRESET after t+2.
  - pending rises at posedge t+N+2 for PRESET=N>=1.
  - PRESET=0 and PRESET=1 both raise pending at t+3.
- Auto-reload:
  - IRQ high for exactly one cycle.
  - Period is N+2 cycles for N>=1.
- Simultaneous events:
  - Software CTRL write in the same cycle as INT's EN<=0: software value wins.
  - Software CTRL write in the same cycle the FSM sets pending: set wins, so the interrupt is never lost.
  - PRESET write in the LOAD cycle: LOAD uses the old PRESET.
- Arithmetic: 32-bit unsigned. COUNT never decrements below 0, so there is no wrap-around.

Decomposition:
- Shared package `timer_pkg`:
  - register offsets TIMER_CTRL=2'd0, TIMER_PRESET=2'd1, TIMER_COUNT=2'd2
  - state encodings S_IDLE/S_LOAD/S_CNT/S_INT (2-bit)
  - mode codes MODE_ONESHOT=2'd0, MODE_RELOAD=2'd1
  - CTRL bit indices
- Single module; no sub-module is warranted.

Test Plan:
- Reset, then reads of CTRL/PRESET/COUNT: all reads return 0 and IRQ=0.
- Write PRESET=5, then CTRL=0x9 (EN, mode 0, IM) at t:
  - COUNT reads 5,4,3,2,1,0.
  - IRQ rises after t+7 and stays high; CTRL reads 0x8.
  - A later write CTRL=0x8 drops IRQ the next cycle.
- PRESET=3, CTRL=0xB (mode 1): IRQ pulses one cycle every 5 cycles for at least 4 periods, and COUNT reloads to 3 after each pulse.
- Mid-count disable:
  - PRESET=10, enable, then write CTRL=0x8 when COUNT=6.
  - Expect state IDLE, COUNT holds 6, no IRQ; re-enable reloads from 10.
- Masked: PRESET=2, CTRL=0x1 (IM=0):
  - IRQ stays 0 at expiry.
  - A subsequent write CTRL=0x8 clears pending, so no spurious IRQ.
- Edge cases:
  - PRESET=0 with enable at t: IRQ after t+3.
  - Reset asserted at COUNT=4: all registers 0, IRQ=0 next cycle.
  - COUNT write of 0x1234 is ignored.
